// File: rtl/axi_rd_pkg.sv
// Shared types and helpers for the AXI4 read-only responder.
package axi_rd_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_BEAT
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Address of the beat following addr for the given burst shape.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                            input logic [7:0] len, input burst_t burst);
    logic [31:0] step;
    logic [31:0] mask;
    logic [31:0] res;
    step = 32'd1 << size;
    mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
    case (burst)
      BURST_INCR: res = addr + step;
      BURST_WRAP: res = (addr & ~mask) | ((addr + step) & mask);
      default:    res = addr;
    endcase
    return res;
  endfunction

  // True when the request shape is one this slave can serve.
  function automatic logic burst_ok(input logic [2:0] size, input logic [7:0] len,
                                    input burst_t burst);
    logic ok;
    ok = (size <= 3'd2) && (burst != BURST_RSVD);
    if (burst == BURST_WRAP)
      ok = ok && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    return ok;
  endfunction

endpackage

// File: rtl/axi_rd_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) with step enable.
// Only instantiated when AXI_RD_RAND_DELAY_EN is defined.
import axi_rd_pkg::*;

module axi_rd_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  output logic [15:0] lfsr
);

  // Shift right, feedback from taps 16,14,13,11 enters at the top bit.
  always_ff @(posedge clock) begin
    if (!reset)
      lfsr <= SEED;
    else if (en)
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

endmodule

// File: rtl/axi_rd_responder.sv
// AXI4 read-only slave over a word-addressed memory image.
// Optional macro AXI_RD_RAND_DELAY_EN inserts LFSR-driven gaps before each beat.
import axi_rd_pkg::*;

module axi_rd_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h80000000,
  parameter int          DEPTH_WORDS = 65536,
  parameter int          LATENCY     = 2,
  parameter              INIT_FILE   = "",
  parameter int          ID_W        = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            arvalid,
  output logic            arready,
  input  logic [31:0]     araddr,
  input  logic [ID_W-1:0] arid,
  input  logic [7:0]      arlen,
  input  logic [2:0]      arsize,
  input  logic [1:0]      arburst,
  output logic            rvalid,
  input  logic            rready,
  output logic [31:0]     rdata,
  output logic [1:0]      rresp,
  output logic            rlast,
  output logic [ID_W-1:0] rid
);

  localparam int          IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [15:0] LAT      = 16'(LATENCY);

  logic [31:0] mem [DEPTH_WORDS];

  state_t      state;
  logic [15:0] cnt;
  logic [31:0] addr_q;
  logic [7:0]  len_q;
  logic [7:0]  beat_q;
  logic [2:0]  size_q;
  burst_t      burst_q;
  logic [2:0]  gap;
  logic [2:0]  gap_seed;

  logic        load;
  logic [31:0] load_addr;
  logic [7:0]  load_beat;
  logic [7:0]  load_len;
  logic        load_ok;
  logic        load_in_range;
  logic [31:0] load_off;
  logic        off_unused;

`ifdef AXI_RD_RAND_DELAY_EN
  logic [15:0] lfsr;
  logic        lfsr_unused;
  axi_rd_lfsr u_lfsr (
    .clock (clock),
    .reset (reset),
    .en    (1'b1),
    .lfsr  (lfsr)
  );
  assign gap_seed    = lfsr[2:0];
  assign lfsr_unused = ^lfsr[15:3];
`else
  assign gap_seed = 3'd0;
`endif

  assign off_unused = ^{load_off[31:IDX_W+2], load_off[1:0]};

  // Decide when a new beat is loaded into the R registers and for which address.
  always_comb begin
    load      = 1'b0;
    load_addr = addr_q;
    load_beat = 8'd0;
    load_len  = len_q;
    load_ok   = burst_ok(size_q, len_q, burst_q);
    case (state)
      ST_IDLE: begin
        if (arvalid && arready && LATENCY == 0) begin
          load      = 1'b1;
          load_addr = araddr;
          load_len  = arlen;
          load_ok   = burst_ok(arsize, arlen, burst_t'(arburst));
        end
      end
      ST_DELAY: begin
        if (cnt == 16'd1) load = 1'b1;
      end
      ST_BEAT: begin
        if (rvalid && rready && !rlast) begin
          load      = 1'b1;
          load_addr = next_addr(addr_q, size_q, len_q, burst_q);
          load_beat = beat_q + 8'd1;
        end
      end
      default: ;
    endcase
    load_off      = load_addr - BASE_ADDR;
    load_in_range = ({1'b0, load_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, load_addr} < END_ADDR);
  end

  // Control FSM with registered AR/R outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= ST_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rresp   <= RESP_OKAY;
      rdata   <= 32'd0;
      rid     <= '0;
      cnt     <= 16'd0;
      beat_q  <= 8'd0;
      gap     <= 3'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          arready <= 1'b1;
          if (arvalid && arready) begin
            arready <= 1'b0;
            addr_q  <= araddr;
            rid     <= arid;
            len_q   <= arlen;
            size_q  <= arsize;
            burst_q <= burst_t'(arburst);
            beat_q  <= 8'd0;
            if (LATENCY == 0) begin
              state <= ST_BEAT;
            end else begin
              state <= ST_DELAY;
              cnt   <= LAT;
            end
          end
        end
        ST_DELAY: begin
          cnt <= cnt - 16'd1;
          if (cnt == 16'd1) state <= ST_BEAT;
        end
        ST_BEAT: begin
          if (rvalid && rready && rlast) begin
            state   <= ST_IDLE;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            arready <= 1'b1;
          end else if (!rvalid && gap != 3'd0) begin
            gap <= gap - 3'd1;
            if (gap == 3'd1) rvalid <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (load) begin
        addr_q <= load_addr;
        beat_q <= load_beat;
        rlast  <= (load_beat == load_len);
        gap    <= gap_seed;
        rvalid <= (gap_seed == 3'd0);
        if (!load_ok) begin
          rresp <= RESP_SLVERR;
          rdata <= 32'd0;
        end else if (!load_in_range) begin
          rresp <= RESP_DECERR;
          rdata <= 32'd0;
        end else begin
          rresp <= RESP_OKAY;
          rdata <= mem[load_off[IDX_W+1:2]];
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_responder.sv
// Self-checking bench for axi_rd_responder: directed table, corner sequences, random reads.
module tb_axi_rd_responder;

  localparam logic [31:0] BASE  = 32'h80000000;
  localparam int          DEPTH = 256;
  localparam int          LAT   = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] araddr = 32'd0;
  logic [3:0]  arid = 4'd0;
  logic [7:0]  arlen = 8'd0;
  logic [2:0]  arsize = 3'd0;
  logic [1:0]  arburst = 2'd0;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] ref_mem [DEPTH];

  axi_rd_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(LAT), .INIT_FILE(""), .ID_W(4)) dut (
    .clock(clock), .reset(reset),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid)
  );

  always #5 clock = ~clock;

`ifdef AXI_RD_RAND_DELAY_EN
  logic [15:0] tb_lfsr = 16'hACE1;
  logic [15:0] tb_lfsr_prev = 16'hACE1;
  always @(posedge clock) begin
    tb_lfsr_prev <= tb_lfsr;
    if (!reset) tb_lfsr <= 16'hACE1;
    else tb_lfsr <= {tb_lfsr[0] ^ tb_lfsr[2] ^ tb_lfsr[3] ^ tb_lfsr[5], tb_lfsr[15:1]};
  end
`endif

  function automatic logic [31:0] word_val(input int i);
    if (i == 0) return 32'hDEADBEEF;
    return 32'h10000000 | 32'(i << 8) | 32'(i);
  endfunction

  // Expected beat i of a request, from the burst rules with plain arithmetic.
  function automatic void model_beat(input logic [31:0] start, input logic [7:0] len,
                                     input logic [2:0] size, input logic [1:0] burst, input int i,
                                     output logic [31:0] data, output logic [1:0] resp);
    longint s, bytes, a, bnd;
    bit bad;
    s = longint'(start);
    bytes = longint'(1) << size;
    bad = (size > 3'd2) || (burst == 2'b11) || (burst == 2'b10 && !(len inside {1, 3, 7, 15}));
    a = s;
    if (burst == 2'b01) a = (s + i * bytes) % (longint'(1) << 32);
    else if (burst == 2'b10 && !bad) begin
      bnd = (longint'(len) + 1) * bytes;
      a = (s / bnd) * bnd + ((s % bnd) + i * bytes) % bnd;
    end
    if (bad) begin
      resp = 2'b10; data = 32'd0;
    end else if (a < longint'(BASE) || a >= longint'(BASE) + 4 * DEPTH) begin
      resp = 2'b11; data = 32'd0;
    end else begin
      resp = 2'b00; data = ref_mem[int'((a - longint'(BASE)) / 4)];
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic issue_ar(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id);
    int w;
    araddr = a; arlen = len; arsize = size; arburst = burst; arid = id; arvalid = 1'b1;
    w = 0;
    while (!arready && w < 50) begin @(posedge clock); #1; w++; end
    chk("ar_ready", arready, 1);
    @(posedge clock); #1;
    arvalid = 1'b0;
  endtask

  // One full read; rready follows pat cyclically; every beat checked against the model.
  task automatic run_txn(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id, input logic [7:0] pat,
                         output logic [31:0] first_data, output logic [1:0] first_resp,
                         output int nbeats);
    int j, cyc, first_c;
    logic [31:0] ed, hold_d;
    logic [1:0] er;
    logic hold_v;
`ifdef AXI_RD_RAND_DELAY_EN
    logic gap_pend, gap_on;
    int gap_cnt, gap_exp;
    gap_pend = 1'b0; gap_on = 1'b0; gap_cnt = 0; gap_exp = 0;
`endif
    first_data = 32'd0; first_resp = 2'd0;
    issue_ar(a, len, size, burst, id);
    j = 0; cyc = 0; first_c = -1; hold_v = 1'b0; hold_d = 32'd0;
    while (j <= int'(len) && cyc < 400) begin
`ifdef AXI_RD_RAND_DELAY_EN
      if (gap_pend) begin gap_exp = int'(tb_lfsr_prev[2:0]); gap_cnt = 0; gap_on = 1'b1; gap_pend = 1'b0; end
      if (gap_on) begin
        if (!rvalid) gap_cnt++;
        else begin chk("gap", gap_cnt, gap_exp); gap_on = 1'b0; end
      end
`endif
      rready = pat[cyc % 8];
      if (hold_v) begin
        chk("hold_valid", rvalid, 1);
        chk("hold_data", rdata, hold_d);
        hold_v = 1'b0;
      end
      if (rvalid && first_c < 0) first_c = cyc;
      if (rvalid && rready) begin
        model_beat(a, len, size, burst, j, ed, er);
        chk("rdata", rdata, ed);
        chk("rresp", rresp, er);
        chk("rlast", rlast, (j == int'(len)));
        chk("rid", rid, id);
        if (j == 0) begin first_data = rdata; first_resp = rresp; end
`ifdef AXI_RD_RAND_DELAY_EN
        if (j != int'(len)) gap_pend = 1'b1;
`endif
        j++;
      end else if (rvalid) begin
        hold_v = 1'b1; hold_d = rdata;
      end
      @(posedge clock); #1;
      cyc++;
    end
    rready = 1'b0;
    nbeats = j;
    chk("beat_count", j, int'(len) + 1);
    chk("rvalid_after_last", rvalid, 0);
    chk("arready_after_last", arready, 1);
`ifndef AXI_RD_RAND_DELAY_EN
    chk("first_latency", first_c, LAT);
`endif
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  id;
    logic [7:0]  pat;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    int          exp_beats;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [31:0] fd;
    logic [1:0] fr;
    int nb, j, cyc;
    logic [31:0] ra;

    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = word_val(i);
      dut.mem[i] = word_val(i);
    end

    vecs[0]  = '{32'h80000000, 8'd0, 3'd2, 2'b01, 4'd1,  8'hFF, 32'hDEADBEEF, 2'b00, 1};
    vecs[1]  = '{32'h80000010, 8'd3, 3'd2, 2'b01, 4'd2,  8'hFF, 32'h10000404, 2'b00, 4};
    vecs[2]  = '{32'h80000010, 8'd3, 3'd2, 2'b01, 4'd2,  8'h99, 32'h10000404, 2'b00, 4};
    vecs[3]  = '{32'h8000001C, 8'd3, 3'd2, 2'b10, 4'd3,  8'hFF, 32'h10000707, 2'b00, 4};
    vecs[4]  = '{32'h80000000, 8'd2, 3'd2, 2'b10, 4'd4,  8'hFF, 32'h00000000, 2'b10, 3};
    vecs[5]  = '{32'h7FFFFFFC, 8'd1, 3'd2, 2'b01, 4'd5,  8'hFF, 32'h00000000, 2'b11, 2};
    vecs[6]  = '{32'h800003FC, 8'd1, 3'd2, 2'b01, 4'd6,  8'hFF, 32'h1000FFFF, 2'b00, 2};
    vecs[7]  = '{32'h80000020, 8'd1, 3'd3, 2'b01, 4'd7,  8'hFF, 32'h00000000, 2'b10, 2};
    vecs[8]  = '{32'h80000020, 8'd1, 3'd2, 2'b11, 4'd8,  8'hFF, 32'h00000000, 2'b10, 2};
    vecs[9]  = '{32'h80000008, 8'd2, 3'd2, 2'b00, 4'd9,  8'h55, 32'h10000202, 2'b00, 3};
    vecs[10] = '{32'h80000001, 8'd3, 3'd0, 2'b01, 4'd10, 8'hFF, 32'hDEADBEEF, 2'b00, 4};

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_arready", arready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rid", rid, 0);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("post_rst_arready", arready, 1);

    // Directed table
    for (int k = 0; k < 11; k++) begin
      run_txn(vecs[k].addr, vecs[k].len, vecs[k].size, vecs[k].burst, vecs[k].id, vecs[k].pat, fd, fr, nb);
      chk($sformatf("vec%0d_data", k), fd, vecs[k].exp_data);
      chk($sformatf("vec%0d_resp", k), fr, vecs[k].exp_resp);
      chk($sformatf("vec%0d_beats", k), nb, vecs[k].exp_beats);
    end

    // Reset taken during beat 2 of a len=7 burst
    rready = 1'b1;
    issue_ar(BASE, 8'd7, 3'd2, 2'b01, 4'hC);
    j = 0; cyc = 0;
    while (j < 2 && cyc < 100) begin
      if (rvalid && rready) j++;
      @(posedge clock); #1;
      cyc++;
    end
    chk("midrst_beats_before", j, 2);
`ifndef AXI_RD_RAND_DELAY_EN
    chk("midrst_beat2_valid", rvalid, 1);
`endif
    reset = 1'b0;
    @(posedge clock); #1;
    chk("midrst_rvalid", rvalid, 0);
    chk("midrst_arready", arready, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    rready = 1'b0;
    @(posedge clock); #1;
    chk("midrst_release_arready", arready, 1);
    chk("midrst_release_rvalid", rvalid, 0);
    run_txn(32'h80000004, 8'd0, 3'd2, 2'b01, 4'd3, 8'hFF, fd, fr, nb);
    chk("midrst_new_data", fd, 32'h10000101);

    // Random requests against the model
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 7))
        0:       ra = BASE - 32'd8 + 32'($urandom_range(0, 3) << 2);
        1:       ra = BASE + 32'h3F0 + 32'($urandom_range(0, 7) << 2);
        default: ra = BASE + 32'($urandom_range(0, DEPTH - 1) << 2) + 32'($urandom_range(0, 3));
      endcase
      run_txn(ra, 8'($urandom_range(0, 15)),
              ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 3)) : 3'd2,
              2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
              8'($urandom) | 8'h01, fd, fr, nb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
